cpu_bus_mapper: RTL and testbench

// - Parametrised CPU address-space mapper for the NES core.
// - Decodes the 16-bit CPU bus into internal WRAM (mirrored), PPU registers
//   (mirrored every 8 bytes), the OAM-DMA trigger register and PRG ROM
//   (16K/32K mirroring).
// - Adds a cycle-accurate OAM DMA engine that stalls the CPU and copies one
//   256-byte page to PPU OAMDATA.
// - Sits between the 6502 core, the PPU register file and the cartridge PRG ROM.

---
 rtl/nes_bus_pkg.sv | 11 +
 rtl/oam_dma_engine.sv | 58 +++++
 rtl/cpu_bus_mapper.sv | 73 +++++++
 tb/tb_cpu_bus_mapper.sv | 123 ++++++++++++
 4 files changed

// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared types, constants and address decode for the NES CPU bus mapper
package nes_bus_pkg;
  typedef enum logic [2:0] {RGN_WRAM, RGN_PPU, RGN_DMA, RGN_OPEN, RGN_PRG} region_t;
  typedef enum logic [1:0] {DMA_IDLE, DMA_ALIGN, DMA_READ, DMA_WRITE} dma_state_t;
  localparam logic [2:0] PPU_OAMDATA = 3'd4;
  localparam int OAM_DMA_BYTES = 256;
  // The DMA register is matched before the $4000-$7FFF open-bus window it lives in
  function automatic region_t region_of(input logic [15:0] a, input logic [15:0] dma_reg);
    return a[15] ? RGN_PRG : (a == dma_reg) ? RGN_DMA : a[14] ? RGN_OPEN : a[13] ? RGN_PPU : RGN_WRAM;
  endfunction
endpackage

// File: rtl/oam_dma_engine.sv
// oam_dma_engine: OAM DMA sequencer (align, then 256 read/write pairs to OAMDATA)
// Ports: clk/reset; i_trig = idle write to the DMA register, i_page = page byte;
// i_rd_hit/i_rd_data = decoded source byte and whether it is a mapped region;
// o_active = DMA running; o_read/o_write = current phase; o_page, o_oam_addr,
// o_byte = source page, byte index and latched source byte.
module oam_dma_engine
  import nes_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_trig,
  input  logic [7:0] i_page,
  input  logic       i_rd_hit,
  input  logic [7:0] i_rd_data,
  output logic       o_active,
  output logic       o_read,
  output logic       o_write,
  output logic [7:0] o_page,
  output logic [7:0] o_oam_addr,
  output logic [7:0] o_byte
);
  dma_state_t r_state, w_next;
  logic       r_par, r_odd;
  logic [7:0] r_page, r_oam, r_byte;
  // r_odd doubles as the extra-cycle flag in ALIGN: cleared after the first align cycle
  always_comb begin
    w_next = r_state == DMA_IDLE  ? (i_trig ? DMA_ALIGN : DMA_IDLE) :
             r_state == DMA_ALIGN ? (r_odd ? DMA_ALIGN : DMA_READ) :
             r_state == DMA_READ  ? DMA_WRITE :
             (r_oam == 8'hFF ? DMA_IDLE : DMA_READ);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DMA_IDLE;
      r_par   <= 1'b0;
      r_odd   <= 1'b0;
      r_page  <= '0;
      r_oam   <= '0;
      r_byte  <= '0;
    end else begin
      r_state <= w_next;
      r_par   <= ~r_par;
      if (r_state == DMA_IDLE && i_trig) begin
        r_page <= i_page;
        r_odd  <= r_par;
      end
      if (r_state == DMA_ALIGN) r_odd <= 1'b0;
      if (r_state == DMA_READ && i_rd_hit) r_byte <= i_rd_data;
      if (r_state == DMA_WRITE) r_oam <= r_oam + 8'd1;
    end
  end
  assign o_active   = r_state != DMA_IDLE;
  assign o_read     = r_state == DMA_READ;
  assign o_write    = r_state == DMA_WRITE;
  assign o_page     = r_page;
  assign o_oam_addr = r_oam;
  assign o_byte     = r_byte;
endmodule

// File: rtl/cpu_bus_mapper.sv
// cpu_bus_mapper: NES CPU address decode (WRAM, PPU regs, OAM DMA, PRG ROM) with OAM DMA
// Ports: clk/reset; addr/WE/data_in from the CPU, data_out registered read data;
// ppu_reg_cs/addr/WE/ppu_data_out to the PPU, ppu_data_in back; prg_addr to PRG ROM,
// prg_data_in back; oam_dma stalls the CPU, oam_addr is the DMA byte index.
module cpu_bus_mapper
  import nes_bus_pkg::*;
#(
  parameter int          WRAM_AW = 11,
  parameter int          PRG_AW  = 15,
  parameter logic [15:0] DMA_REG = 16'h4014
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic              WE,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              ppu_reg_cs,
  output logic [2:0]        ppu_reg_addr,
  output logic              ppu_reg_WE,
  output logic [7:0]        ppu_data_out,
  input  logic [7:0]        ppu_data_in,
  output logic [PRG_AW-1:0] prg_addr,
  input  logic [7:0]        prg_data_in,
  output logic              oam_dma,
  output logic [7:0]        oam_addr
);
  logic [7:0]  r_wram [2**WRAM_AW];
  logic [7:0]  r_data_out;
  logic        w_read, w_write, w_hit, w_ppu_sel, w_cpu_we, w_trig;
  logic [7:0]  w_page, w_byte, w_rd;
  logic [15:0] w_ea;
  region_t     w_rgn;
  // DMA reads reuse the CPU decode path with the internal {page, index} address
  always_comb begin
    w_ea         = w_read ? {w_page, oam_addr} : addr;
    w_rgn        = region_of(w_ea, DMA_REG);
    w_cpu_we     = !oam_dma && WE;
    w_trig       = w_cpu_we && w_rgn == RGN_DMA;
    w_hit        = w_rgn inside {RGN_WRAM, RGN_PPU, RGN_PRG};
    w_rd         = w_rgn == RGN_WRAM ? r_wram[w_ea[WRAM_AW-1:0]] :
                   w_rgn == RGN_PPU  ? ppu_data_in : prg_data_in;
    w_ppu_sel    = (!oam_dma || w_read) && w_rgn == RGN_PPU;
    ppu_reg_cs   = !reset && (w_write || w_ppu_sel);
    ppu_reg_WE   = !reset && (w_write || (w_ppu_sel && w_cpu_we));
    ppu_reg_addr = reset ? 3'd0 : w_write ? PPU_OAMDATA : w_ea[2:0];
    ppu_data_out = reset ? 8'd0 : w_write ? w_byte : data_in;
    prg_addr     = w_ea[PRG_AW-1:0];
  end
  always_ff @(posedge clk) begin
    if (!reset && w_cpu_we && w_rgn == RGN_WRAM) r_wram[w_ea[WRAM_AW-1:0]] <= data_in;
  end
  // Unmapped and DMA-register reads leave data_out untouched (open bus)
  always_ff @(posedge clk) begin
    if (reset) r_data_out <= '0;
    else if (!oam_dma && !WE && w_hit) r_data_out <= w_rd;
  end
  assign data_out = r_data_out;
  oam_dma_engine u_dma (
    .clk       (clk),
    .reset     (reset),
    .i_trig    (w_trig),
    .i_page    (data_in),
    .i_rd_hit  (w_hit),
    .i_rd_data (w_rd),
    .o_active  (oam_dma),
    .o_read    (w_read),
    .o_write   (w_write),
    .o_page    (w_page),
    .o_oam_addr(oam_addr),
    .o_byte    (w_byte)
  );
endmodule

// File: tb/tb_cpu_bus_mapper.sv
// tb_cpu_bus_mapper: directed self-checking bench for cpu_bus_mapper (PRG_AW=14)
module tb_cpu_bus_mapper;
  logic        clk = 0, reset = 1, WE = 0;
  logic [15:0] addr = 16'h5000;
  logic [7:0]  data_in = 0, data_out, ppu_data_out, ppu_data_in, prg_data_in, oam_addr;
  logic        ppu_reg_cs, ppu_reg_WE, oam_dma;
  logic [2:0]  ppu_reg_addr;
  logic [13:0] prg_addr;
  logic        tb_par;
  int          n_chk = 0, n_err = 0;
  cpu_bus_mapper #(.WRAM_AW(11), .PRG_AW(14), .DMA_REG(16'h4014)) dut (
    .clk(clk), .reset(reset), .addr(addr), .WE(WE), .data_in(data_in), .data_out(data_out),
    .ppu_reg_cs(ppu_reg_cs), .ppu_reg_addr(ppu_reg_addr), .ppu_reg_WE(ppu_reg_WE),
    .ppu_data_out(ppu_data_out), .ppu_data_in(ppu_data_in), .prg_addr(prg_addr),
    .prg_data_in(prg_data_in), .oam_dma(oam_dma), .oam_addr(oam_addr)
  );
  always #5 clk = ~clk;
  assign ppu_data_in = {5'h15, ppu_reg_addr};
  assign prg_data_in = prg_addr[7:0] ^ 8'h5A;
  always @(posedge clk) tb_par <= reset ? 1'b0 : ~tb_par;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d);
    addr = a; WE = w; data_in = d; #1;
  endtask
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic run_dma(input logic odd, input logic [7:0] hold);
    int hi = 0, nw = 0;
    if (tb_par != odd) begin bus(16'h5000, 0, 0); tick; end
    bus(16'h4014, 1, 8'h02); tick;
    bus(16'h4014, 1, 8'h77);
    for (int c = 0; c < 600 && oam_dma; c++) begin
      if (ppu_reg_cs && ppu_reg_WE && ppu_reg_addr == 3'd4) begin
        check("dma_data", {8'h0, ppu_data_out}, 16'(nw & 255));
        check("dma_idx", {8'h0, oam_addr}, 16'(nw & 255));
        nw++;
      end
      hi++;
      tick;
    end
    bus(16'h5000, 0, 0);
    check("dma_len", 16'(hi), odd ? 16'd514 : 16'd513);
    check("dma_writes", 16'(nw), 16'd256);
    check("dma_wrap", {8'h0, oam_addr}, 16'h0);
    check("dma_hold", {8'h0, data_out}, {8'h0, hold});
    tick;
    check("dma_no_retrig", {15'h0, oam_dma}, 16'h0);
  endtask
  initial begin
    int nw;
    bus(16'h2000, 1, 8'hFF); tick; tick;
    check("rst_data_out", {8'h0, data_out}, 16'h0);
    check("rst_oam_dma", {15'h0, oam_dma}, 16'h0);
    check("rst_oam_addr", {8'h0, oam_addr}, 16'h0);
    check("rst_cs", {15'h0, ppu_reg_cs}, 16'h0);
    check("rst_we", {15'h0, ppu_reg_WE}, 16'h0);
    check("rst_pdata", {8'h0, ppu_data_out}, 16'h0);
    reset = 0;
    bus(16'h0005, 1, 8'hA5); tick;
    bus(16'h1805, 0, 0); tick;
    check("wram_mirror", {8'h0, data_out}, 16'h00A5);
    bus(16'h07FF, 1, 8'h11); tick;
    bus(16'h1FFF, 0, 0); tick;
    check("wram_top", {8'h0, data_out}, 16'h0011);
    bus(16'h3FFC, 1, 8'h3C);
    check("ppu_cs", {15'h0, ppu_reg_cs}, 16'h1);
    check("ppu_addr", {13'h0, ppu_reg_addr}, 16'h4);
    check("ppu_we", {15'h0, ppu_reg_WE}, 16'h1);
    check("ppu_wdata", {8'h0, ppu_data_out}, 16'h003C);
    tick;
    bus(16'h2002, 0, 0);
    check("ppu_rd_cs", {15'h0, ppu_reg_cs}, 16'h1);
    check("ppu_rd_we", {15'h0, ppu_reg_WE}, 16'h0);
    check("ppu_rd_addr", {13'h0, ppu_reg_addr}, 16'h2);
    tick;
    check("ppu_rdata", {8'h0, data_out}, 16'h00AA);
    bus(16'hC123, 0, 0);
    check("prg_addr_c", {2'b0, prg_addr}, 16'h0123);
    check("prg_no_cs", {15'h0, ppu_reg_cs}, 16'h0);
    tick;
    check("prg_data", {8'h0, data_out}, 16'h0079);
    bus(16'h8123, 0, 0);
    check("prg_addr_8", {2'b0, prg_addr}, 16'h0123);
    bus(16'h0005, 0, 0); tick;
    check("open_pre", {8'h0, data_out}, 16'h00A5);
    bus(16'h5000, 0, 0); tick;
    check("open_5000", {8'h0, data_out}, 16'h00A5);
    bus(16'h4014, 0, 0); tick;
    check("open_4014", {8'h0, data_out}, 16'h00A5);
    check("open_no_dma", {15'h0, oam_dma}, 16'h0);
    for (int i = 0; i < 256; i++) begin
      bus(16'h0200 + 16'(i), 1, 8'(i)); tick;
    end
    bus(16'h5000, 0, 0); tick;
    run_dma(1'b0, 8'hA5);
    run_dma(1'b1, 8'hA5);
    bus(16'h4014, 1, 8'h02); tick;
    for (int c = 0; c < 400 && oam_addr != 8'd100; c++) tick;
    check("mid_reach", {8'h0, oam_addr}, 16'd100);
    reset = 1; bus(16'h5000, 0, 0); tick;
    check("mid_oam_dma", {15'h0, oam_dma}, 16'h0);
    check("mid_oam_addr", {8'h0, oam_addr}, 16'h0);
    check("mid_cs", {15'h0, ppu_reg_cs}, 16'h0);
    reset = 0;
    nw = 0;
    for (int c = 0; c < 6; c++) begin
      if (ppu_reg_cs && ppu_reg_WE) nw++;
      tick;
    end
    check("mid_no_wr", 16'(nw), 16'h0);
    check("mid_idle", {15'h0, oam_dma}, 16'h0);
    run_dma(1'b0, 8'h00);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
